// File: rtl/nic_pkg.sv
// Shared rf68000 ring packet definitions.
//  packet_t        : one ring slot (sid/did/age/data)
//  AGE_MAX_DEFAULT : default scrub threshold for ring schedulers
//  pkt_empty()     : empty-slot test, shared with rf68000_nic
package nic_pkg;

  typedef struct packed {
    logic [5:0]  sid;
    logic [5:0]  did;
    logic [5:0]  age;
    logic [15:0] data;
  } packet_t;

  localparam logic [5:0] AGE_MAX_DEFAULT = 6'd48;
  localparam logic [5:0] DID_BCAST       = 6'd63;

  // A slot is free when it carries neither source nor destination id.
  function automatic logic pkt_empty(input packet_t p);
    return (p.sid | p.did) == 6'd0;
  endfunction

endpackage

// File: rtl/rf68000_rr_arb.sv
// Combinational round-robin arbiter.
//  req  : request vector
//  ptr  : highest-priority index this cycle
//  en   : grant enable
//  gnt  : one-hot grant
//  idx  : winner index
//  any  : a grant is issued
module rf68000_rr_arb #(
  parameter int NREQ = 4,
  localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   idx,
  output logic            any
);

  // Walk from ptr upward with wrap; one extra bit holds ptr+i before wrap.
  always_comb begin
    logic [PW:0] s;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    s   = '0;
    for (int i = 0; i < NREQ; i++) begin
      s = {1'b0, ptr} + (PW+1)'(i);
      if (s >= (PW+1)'(NREQ)) s = s - (PW+1)'(NREQ);
      if (en && !any && req[s[PW-1:0]]) begin
        any            = 1'b1;
        idx            = s[PW-1:0];
        gnt[s[PW-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf68000_ring_sched.sv
// Ring injection scheduler for one rf68000 ring node.
//  clk_i/rst_ni : clock, async active-low reset
//  en_i         : grant enable (does not abort a pending injection)
//  req_i/req_pkt_i/gnt_o : local requesters, round-robin, one-cycle grant
//  packet_i/packet_o     : ring in / registered ring out
//  busy_o       : transmit buffer holds a packet
//  drop_o/drop_cnt_o     : scrub pulse / saturating scrub count
//  timeout_o    : pulse when a latched packet has waited TIMEOUT cycles
module rf68000_ring_sched
  import nic_pkg::*;
#(
  parameter int         NREQ    = 4,
  parameter logic [5:0] MAX_AGE = AGE_MAX_DEFAULT,
  parameter logic [15:0] TIMEOUT = 16'd1024
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic [NREQ-1:0]      req_i,
  input  packet_t [NREQ-1:0]   req_pkt_i,
  output logic [NREQ-1:0]      gnt_o,
  input  packet_t              packet_i,
  output packet_t              packet_o,
  output logic                 busy_o,
  output logic                 drop_o,
  output logic [15:0]          drop_cnt_o,
  output logic                 timeout_o
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {ST_IDLE, ST_HOLD} state_t;

  state_t          state;
  packet_t         txbuf;
  logic [PW-1:0]   rr_ptr;
  logic [15:0]     wait_cnt;

  logic [NREQ-1:0] arb_gnt;
  logic [PW-1:0]   arb_idx;
  logic            arb_any;

  rf68000_rr_arb #(.NREQ(NREQ)) u_arb (
    .req (req_i),
    .ptr (rr_ptr),
    .en  (en_i && state == ST_IDLE),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  logic    slot_empty, scrub, slot_free;
  packet_t fwd_pkt, pick_pkt;

  always_comb begin
    slot_empty = pkt_empty(packet_i);
    scrub      = !slot_empty && (packet_i.age >= MAX_AGE);
    // A scrubbed slot is as good as an empty one for injection.
    slot_free  = slot_empty || scrub;

    fwd_pkt = packet_i;
    if (scrub)
      fwd_pkt = '0;
    else if (!slot_empty && packet_i.age != 6'd63)
      fwd_pkt.age = packet_i.age + 6'd1;

    // Broadcasts keep the offered age so their ring lifetime is bounded
    // from the originator, not restarted here.
    pick_pkt = req_pkt_i[arb_idx];
    if (pick_pkt.did != DID_BCAST) pick_pkt.age = 6'd0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= ST_IDLE;
      txbuf      <= '0;
      rr_ptr     <= '0;
      wait_cnt   <= '0;
      packet_o   <= '0;
      gnt_o      <= '0;
      busy_o     <= 1'b0;
      drop_o     <= 1'b0;
      drop_cnt_o <= '0;
      timeout_o  <= 1'b0;
    end else begin
      packet_o  <= fwd_pkt;
      gnt_o     <= '0;
      drop_o    <= scrub;
      timeout_o <= 1'b0;
      if (scrub && drop_cnt_o != 16'hFFFF) drop_cnt_o <= drop_cnt_o + 16'd1;

      case (state)
        ST_IDLE: begin
          // Latch only; injection waits for a later free slot.
          if (arb_any) begin
            txbuf    <= pick_pkt;
            gnt_o    <= arb_gnt;
            rr_ptr   <= (arb_idx == PW'(NREQ-1)) ? '0 : arb_idx + PW'(1);
            wait_cnt <= '0;
            busy_o   <= 1'b1;
            state    <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (slot_free) begin
            packet_o <= txbuf;
            txbuf    <= '0;
            busy_o   <= 1'b0;
            state    <= ST_IDLE;
          end else if (wait_cnt != 16'hFFFF) begin
            wait_cnt <= wait_cnt + 16'd1;
            if (wait_cnt + 16'd1 == TIMEOUT) timeout_o <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/rf68000_ring_sched.md
Name: rf68000_ring_sched

Overview:
- Ring injection scheduler for one node of the rf68000 packet ring.
- Shares the node's single ring transmit slot among NREQ local requesters (CPU bus bridge, DMA, IRQ forwarder, ...) using round-robin arbitration.
- Forwards through-traffic with age increment and scrubs over-aged packets so orphaned packets cannot circulate forever.
- Sits in the ring path ahead of rf68000_nic: packet_i from upstream node, packet_o to downstream.

Parameters:
- NREQ, 4, number of local requesters (2..8).
- MAX_AGE, 6'd48, incoming non-empty packet with age >= MAX_AGE is scrubbed.
- TIMEOUT, 16'd1024, cycles a latched packet may wait for an empty slot before timeout_o pulses.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- en_i  in  1  grant enable; low blocks new grants only.
- req_i  in  NREQ  request per requester; held with stable data until granted.
- req_pkt_i  in  NREQ x packet_t  packet offered by each requester.
- gnt_o  out  NREQ  one-hot, one-cycle grant pulse; packet was latched.
- packet_i  in  packet_t  ring input.
- packet_o  out  packet_t  ring output (registered).
- busy_o  out  1  transmit buffer occupied.
- drop_o  out  1  one-cycle pulse when a packet is scrubbed.
- drop_cnt_o  out  16  saturating scrubbed-packet count.
- timeout_o  out  1  one-cycle pulse at wait count == TIMEOUT.

Behaviour:
- Empty slot: (packet_i.sid|packet_i.did)==0.
- Reset (async assert, sync deassert): packet_o=0, gnt_o=0, busy_o=0, drop_o=0, drop_cnt_o=0, timeout_o=0, rr_ptr=0, txbuf=0, wait_cnt=0, state=ST_IDLE. Reset mid-HOLD discards txbuf; the requester was already granted, so that packet is lost by design.
- Forwarding, every cycle, default:
  - packet_o <= packet_i, with age+1 saturating at 63.
  - Empty slots are forwarded unchanged (all-zero, no age increment).
- Scrub: if the slot is non-empty and packet_i.age >= MAX_AGE:
  - packet_o <= 0.
  - drop_o pulses.
  - drop_cnt_o++, saturating at 16'hFFFF.
  - The scrubbed slot counts as empty for injection in the same cycle.
- States:
  - ST_IDLE:
    - If en_i and |req_i, winner k = first set bit of req_i searching from rr_ptr upward with wrap.
    - txbuf <= req_pkt_i[k], with age forced to 0 except when did==63 (broadcast keeps offered age).
    - gnt_o[k]=1 for exactly one cycle; rr_ptr <= (k+1) mod NREQ; wait_cnt <= 0; busy_o <= 1; go ST_HOLD.
    - No grant when en_i is low or no request is present.
  - ST_HOLD:
    - If the slot is empty or scrubbed this cycle: packet_o <= txbuf; txbuf <= 0; busy_o <= 0; go ST_IDLE.
    - Otherwise wait_cnt++, saturating at 16'hFFFF. timeout_o pulses once, on the cycle wait_cnt becomes TIMEOUT. Remain in ST_HOLD; the packet is never dropped.
    - No new grants while in ST_HOLD. en_i low does not abort the pending injection.
- Latency:
  - Request to grant: 1 cycle (req_i sampled, gnt_o registered).
  - Grant to earliest packet_o: 1 cycle after the grant, when an empty slot is present.
  - Through-traffic: 1 cycle.
- Simultaneous events:
  - Injection and scrub on the same cycle: the injected packet wins the output, and drop_o still pulses.
  - Request and empty slot on the same cycle in ST_IDLE: latch only; inject on a later empty slot.
- A requester must keep req_i high until gnt_o. Dropping req_i before grant withdraws the request with no side effect.
- Max one injection per cycle. A sustained ring load of 100% non-empty, non-aged slots starves injection; timeout_o reports it.

Decomposition:
- nic_pkg holds: packet_t (already present), a new constant AGE_MAX_DEFAULT, and a function pkt_empty(packet_t) returning the empty-slot test, shared with rf68000_nic.
- Sub-module rf68000_rr_arb(NREQ):
  - Inputs: req, ptr, en. Outputs: one-hot grant, winner index, any.
  - Combinational; reusable by other shared-resource blocks.

Test Plan:
- Idle ring, req_i=4'b0001 with pkt sid=5,did=62,age=9: gnt_o[0] at cycle 1; packet_o equals the pkt with age=0 at cycle 2; busy_o 1 then 0.
- Idle ring, req_i=4'b1011 held: grants occur in order 0,1,3,0,1,3; each grant is followed by an injection; rr_ptr wraps correctly.
- Ring full of age=10 packets for 1100 cycles with one latched request:
  - packet_o carries age=11 copies.
  - timeout_o pulses once at wait_cnt==1024.
  - Injection occurs on the first empty slot supplied afterward.
- Incoming packet age=48 with nothing pending: packet_o=0, drop_o=1, drop_cnt_o=1. Age=47 is forwarded as 48 and not dropped.
- ST_HOLD with an aged packet arriving: txbuf is injected into that slot, drop_o pulses, drop_cnt_o increments.
- en_i=0 with req_i=4'b0100: no gnt_o. Assert rst_ni low mid-ST_HOLD: all outputs go to 0 immediately (async), and no injection follows after release.
